// File: rtl/bcp_pkg.sv
// rtl/bcp_pkg.sv - shared types and widths for the BCP engine
package bcp_pkg;
    localparam int MAX_VARS_BITS    = 6;
    localparam int MAX_CLAUSES_BITS = 6;
    localparam int LIT_W            = MAX_VARS_BITS + 1;

    localparam logic [MAX_VARS_BITS-1:0] NULL_VAR = '0;
    localparam logic TYPE_DECIDED = 1'b0;
    localparam logic TYPE_IMPLIED = 1'b1;

    typedef struct packed {
        logic                     pol;
        logic [MAX_VARS_BITS-1:0] var_id;
    } literal_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SCAN,
        S_EMIT,
        S_CONFLICT
    } bcp_state_e;
endpackage

// File: rtl/bcp_if.sv
// rtl/bcp_if.sv - clause stream, memory lookups, implication push and status of the BCP engine
interface bcp_if
    import bcp_pkg::*;
#(
    parameter int MAX_LITS = 4
) ();
    logic                          clause_valid;
    logic [MAX_CLAUSES_BITS-1:0]   clause_idx;
    logic                          clause_ready;
    logic                          clause_rd_en;
    logic [MAX_CLAUSES_BITS-1:0]   clause_rd_addr;
    logic [MAX_LITS*LIT_W-1:0]     clause_rd_data;
    logic                          vs_rd_en;
    logic [MAX_VARS_BITS-1:0]      vs_rd_var;
    logic                          vs_rd_val;
    logic                          vs_rd_unassign;
    logic                          full_imply;
    logic                          push_imply;
    logic [MAX_VARS_BITS-1:0]      var_in_imply;
    logic                          val_in_imply;
    logic                          type_in_imply;
    logic                          bcp_busy;
    logic                          conflict;
    logic [MAX_CLAUSES_BITS-1:0]   conflict_clause;
    logic                          overflow;

    modport slave (
        input  clause_valid, clause_idx, clause_rd_data, vs_rd_val, vs_rd_unassign, full_imply,
        output clause_ready, clause_rd_en, clause_rd_addr, vs_rd_en, vs_rd_var,
               push_imply, var_in_imply, val_in_imply, type_in_imply,
               bcp_busy, conflict, conflict_clause, overflow
    );

    modport master (
        output clause_valid, clause_idx, clause_rd_data, vs_rd_val, vs_rd_unassign, full_imply,
        input  clause_ready, clause_rd_en, clause_rd_addr, vs_rd_en, vs_rd_var,
               push_imply, var_in_imply, val_in_imply, type_in_imply,
               bcp_busy, conflict, conflict_clause, overflow
    );
endinterface

// File: rtl/bcp_clause_fifo.sv
// rtl/bcp_clause_fifo.sv - synchronous clause-index FIFO; pushes while full are dropped and flagged
module bcp_clause_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         clr_ovf,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          w_do_push, w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];
    assign overflow  = r_overflow;

    always_ff @(posedge clock) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
            end
            if (clr_ovf)           r_overflow <= 1'b0;
            else if (push && full) r_overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/bcp_engine.sv
// rtl/bcp_engine.sv - clause evaluation and unit implication engine; BCP_EARLY_EXIT_EN stops the scan at the first true literal
module bcp_engine
    import bcp_pkg::*;
#(
    parameter int MAX_LITS   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   reset_bcp,
    bcp_if.slave   bus
);
    localparam int             SW        = $clog2(MAX_LITS + 1);
    localparam logic [SW-1:0]  LAST_SLOT = SW'(MAX_LITS);

    bcp_state_e                  r_state, w_next;
    literal_t                    r_lits [MAX_LITS];
    literal_t                    r_pend_lit, r_last, w_cur_lit, w_last;
    logic [MAX_CLAUSES_BITS-1:0] r_cur_idx, r_conf_idx;
    logic [SW-1:0]               r_slot;
    logic                        r_pend_valid, r_sat, r_conflict;
    logic [1:0]                  r_cnt, w_cnt;
    logic                        w_true, w_unas, w_sat, w_stop_early, w_vs_rd_en;
    logic                        w_fifo_push, w_fifo_pop, w_fifo_full, w_fifo_empty, w_fifo_ovf;
    logic [MAX_CLAUSES_BITS-1:0] w_fifo_dout;

    assign w_fifo_push = bus.clause_valid && !reset_bcp && (r_state != S_CONFLICT);
    assign w_fifo_pop  = (r_state == S_IDLE) && !w_fifo_empty && !reset_bcp;

    bcp_clause_fifo #(.DEPTH(FIFO_DEPTH), .W(MAX_CLAUSES_BITS)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (reset_bcp || (r_state == S_CONFLICT)),
        .clr_ovf  (reset_bcp),
        .push     (w_fifo_push),
        .pop      (w_fifo_pop),
        .din      (bus.clause_idx),
        .dout     (w_fifo_dout),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty),
        .overflow (w_fifo_ovf)
    );

    always_comb begin
        w_cur_lit = '0;
        for (int k = 0; k < MAX_LITS; k++) begin
            if (r_slot == SW'(k)) w_cur_lit = r_lits[k];
        end
    end

    // Lookup issued last cycle is evaluated here while the next slot's lookup goes out.
    assign w_true = r_pend_valid && !bus.vs_rd_unassign && (bus.vs_rd_val == r_pend_lit.pol);
    assign w_unas = r_pend_valid && bus.vs_rd_unassign;
    assign w_sat  = r_sat || w_true;
    assign w_cnt  = (w_unas && (r_cnt != 2'd2)) ? r_cnt + 2'd1 : r_cnt;
    assign w_last = w_unas ? r_pend_lit : r_last;

`ifdef BCP_EARLY_EXIT_EN
    assign w_stop_early = (r_state == S_SCAN) && w_true;
`else
    assign w_stop_early = 1'b0;
`endif

    assign w_vs_rd_en = (r_state == S_SCAN) && (r_slot != LAST_SLOT) &&
                        (w_cur_lit.var_id != NULL_VAR) && !w_stop_early && !reset_bcp;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_fifo_empty) w_next = S_FETCH;
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_SCAN;
            S_SCAN: begin
                if (w_stop_early) begin
                    w_next = S_IDLE;
                end else if (r_slot == LAST_SLOT) begin
                    if (w_sat)                w_next = S_IDLE;
                    else if (w_cnt == 2'd0)   w_next = S_CONFLICT;
                    else if (w_cnt == 2'd1)   w_next = S_EMIT;
                    else                      w_next = S_IDLE;
                end
            end
            S_EMIT:     if (!bus.full_imply) w_next = S_IDLE;
            S_CONFLICT: w_next = S_CONFLICT;
            default:    w_next = S_IDLE;
        endcase
        if (reset_bcp) w_next = S_IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < MAX_LITS; k++) r_lits[k] <= '0;
            r_pend_lit   <= '0;
            r_last       <= '0;
            r_cur_idx    <= '0;
            r_conf_idx   <= '0;
            r_slot       <= '0;
            r_pend_valid <= 1'b0;
            r_sat        <= 1'b0;
            r_cnt        <= '0;
            r_conflict   <= 1'b0;
        end else if (reset_bcp) begin
            r_pend_valid <= 1'b0;
            r_conflict   <= 1'b0;
            r_conf_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_fifo_pop) r_cur_idx <= w_fifo_dout;
                S_FETCH: begin
                    for (int k = 0; k < MAX_LITS; k++)
                        r_lits[k] <= literal_t'(bus.clause_rd_data[k*LIT_W +: LIT_W]);
                end
                S_LOAD: begin
                    r_slot       <= '0;
                    r_pend_valid <= 1'b0;
                    r_sat        <= 1'b0;
                    r_cnt        <= '0;
                    r_last       <= '0;
                end
                S_SCAN: begin
                    r_slot       <= r_slot + 1'b1;
                    r_pend_valid <= w_vs_rd_en;
                    r_pend_lit   <= w_cur_lit;
                    r_sat        <= w_sat;
                    r_cnt        <= w_cnt;
                    r_last       <= w_last;
                    if (w_next == S_CONFLICT) begin
                        r_conflict <= 1'b1;
                        r_conf_idx <= r_cur_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.clause_ready    = !w_fifo_full;
    assign bus.clause_rd_en    = w_fifo_pop;
    assign bus.clause_rd_addr  = w_fifo_pop ? w_fifo_dout : '0;
    assign bus.vs_rd_en        = w_vs_rd_en;
    assign bus.vs_rd_var       = w_vs_rd_en ? w_cur_lit.var_id : '0;
    assign bus.push_imply      = (r_state == S_EMIT) && !bus.full_imply && !reset_bcp;
    assign bus.var_in_imply    = (r_state == S_EMIT) ? r_last.var_id : '0;
    assign bus.val_in_imply    = (r_state == S_EMIT) ? r_last.pol : 1'b0;
    assign bus.type_in_imply   = (r_state == S_EMIT) ? TYPE_IMPLIED : TYPE_DECIDED;
    assign bus.bcp_busy        = (r_state != S_CONFLICT) &&
                                 (bus.clause_valid || !w_fifo_empty || (r_state != S_IDLE));
    assign bus.conflict        = r_conflict;
    assign bus.conflict_clause = r_conf_idx;
    assign bus.overflow        = w_fifo_ovf;
endmodule

// File: tb/tb_bcp_engine.sv
// tb/tb_bcp_engine.sv - directed and randomized checks of bcp_engine against a clause-level reference model
module tb_bcp_engine;
    import bcp_pkg::*;

    localparam int NL    = 4;
    localparam int DEPTH = 8;
    localparam int CW    = NL * LIT_W;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic reset_bcp = 1'b0;

    bcp_if #(.MAX_LITS(NL)) bus ();

    bcp_engine #(.MAX_LITS(NL), .FIFO_DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .reset_bcp (reset_bcp),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    logic [CW-1:0] clause_mem [64];
    logic          var_val [64];
    logic          var_asg [64];

    always @(posedge clock) begin
        if (bus.clause_rd_en) bus.clause_rd_data <= clause_mem[bus.clause_rd_addr];
        if (bus.vs_rd_en) begin
            bus.vs_rd_val      <= var_val[bus.vs_rd_var];
            bus.vs_rd_unassign <= !var_asg[bus.vs_rd_var];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    int m_cyc, m_npush, m_nread, m_done;
    int m_pvar, m_pval, m_ptype;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // kind: 0 satisfied, 1 unit, 2 conflict, 3 two or more unassigned
    function automatic void ref_eval(input logic [CW-1:0] word, output int kind, output int uvar,
                                     output int uval, output int reads, output int first_true);
        int  n_unas = 0;
        bit  sat = 0;
        logic [LIT_W-1:0] lit;
        uvar = 0; uval = 0; reads = 0; first_true = -1;
        for (int k = 0; k < NL; k++) begin
            lit = word[k*LIT_W +: LIT_W];
            if (lit[MAX_VARS_BITS-1:0] != 0) begin
                if (!(sat && first_true >= 0)) reads++;
                if (var_asg[lit[MAX_VARS_BITS-1:0]]) begin
                    if (var_val[lit[MAX_VARS_BITS-1:0]] == lit[MAX_VARS_BITS] && !sat) begin
                        sat = 1;
                        first_true = k;
                    end
                end else begin
                    n_unas++;
                    uvar = int'(lit[MAX_VARS_BITS-1:0]);
                    uval = int'(lit[MAX_VARS_BITS]);
                end
            end
        end
`ifndef BCP_EARLY_EXIT_EN
        reads = 0;
        for (int k = 0; k < NL; k++) begin
            lit = word[k*LIT_W +: LIT_W];
            if (lit[MAX_VARS_BITS-1:0] != 0) reads++;
        end
`endif
        if (sat)              kind = 0;
        else if (n_unas == 0) kind = 2;
        else if (n_unas == 1) kind = 1;
        else                  kind = 3;
    endfunction

    task automatic run_clause(input int idx);
        m_cyc = 0; m_npush = 0; m_nread = 0; m_done = 0;
        m_pvar = 0; m_pval = 0; m_ptype = 0;
        tick();
        bus.clause_valid = 1'b1;
        bus.clause_idx   = MAX_CLAUSES_BITS'(idx);
        #1;
        for (int n = 0; n < 60; n++) begin
            if (bus.push_imply) begin
                m_npush++;
                m_pvar  = int'(bus.var_in_imply);
                m_pval  = int'(bus.val_in_imply);
                m_ptype = int'(bus.type_in_imply);
            end
            if (bus.vs_rd_en) m_nread++;
            if (!bus.bcp_busy) begin
                m_done = 1;
                break;
            end
            m_cyc++;
            tick();
            bus.clause_valid = 1'b0;
            #1;
        end
        bus.clause_valid = 1'b0;
    endtask

    task automatic clear_bcp();
        tick();
        reset_bcp = 1'b1;
        tick();
        reset_bcp = 1'b0;
        #1;
    endtask

    task automatic run_and_check(input int idx, input bit auto_clear);
        int kind, uvar, uval, reads, ft, exp_cyc;
        ref_eval(clause_mem[idx], kind, uvar, uval, reads, ft);
        run_clause(idx);
        check("clause_done", m_done, 1);
        check("push_count", m_npush, (kind == 1) ? 1 : 0);
        if (kind == 1) begin
            check("imply_var", m_pvar, uvar);
            check("imply_val", m_pval, uval);
            check("imply_type", m_ptype, 1);
        end
        check("conflict_flag", bus.conflict, (kind == 2) ? 1 : 0);
        if (kind == 2) check("conflict_clause", bus.conflict_clause, idx);
`ifdef BCP_EARLY_EXIT_EN
        exp_cyc = (kind == 0) ? ft + 6 : NL + 5;
`else
        exp_cyc = NL + 5;
`endif
        if (kind == 1) exp_cyc++;
        check("busy_cycles", m_cyc, exp_cyc);
        check("vs_reads", m_nread, reads);
        if (kind == 2 && auto_clear) clear_bcp();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] w;
        int accepted[$];
        int pushes[$];
        int saw_full, busy_viol, first_push, push_cnt, rd_cnt, done;

        bus.clause_valid = 1'b0;
        bus.clause_idx   = '0;
        bus.full_imply   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            clause_mem[i] = '0;
            var_val[i]    = 1'b0;
            var_asg[i]    = 1'b0;
        end

        repeat (3) @(posedge clock);
        #1;
        check("reset_outs_in_reset",
              {bus.clause_ready, bus.bcp_busy, bus.conflict, bus.overflow,
               bus.push_imply, bus.clause_rd_en, bus.vs_rd_en, bus.type_in_imply}, 32'h80);
        reset = 1'b1;
        tick();
        check("reset_outs",
              {bus.clause_ready, bus.bcp_busy, bus.conflict, bus.overflow,
               bus.push_imply, bus.clause_rd_en, bus.vs_rd_en, bus.type_in_imply}, 32'h80);

        // clause 5 = {x1+, x2-, x3+, NULL}
        w = '0;
        w[0*LIT_W +: LIT_W] = {1'b1, 6'd1};
        w[1*LIT_W +: LIT_W] = {1'b0, 6'd2};
        w[2*LIT_W +: LIT_W] = {1'b1, 6'd3};
        clause_mem[5] = w;
        var_asg[1] = 1; var_val[1] = 0;
        var_asg[2] = 1; var_val[2] = 1;
        var_asg[3] = 0;
        run_and_check(5, 1'b1);
        check("unit_push_once", m_npush, 1);
        check("unit_var3", m_pvar, 3);
        check("unit_val1", m_pval, 1);

        // x1 true: satisfied at slot 0
        var_val[1] = 1;
        run_and_check(5, 1'b1);
        check("sat_no_push", m_npush, 0);
        var_val[1] = 0;

        for (int it = 0; it < 40; it++) begin
            int idx;
            idx = 32 + $urandom_range(0, 31);
            for (int v = 1; v < 8; v++) begin
                var_asg[v] = ($urandom_range(0, 2) != 0);
                var_val[v] = $urandom_range(0, 1);
            end
            w = '0;
            for (int k = 0; k < NL; k++) begin
                if ($urandom_range(0, 3) != 0)
                    w[k*LIT_W +: LIT_W] = {1'($urandom_range(0, 1)), 6'($urandom_range(1, 7))};
            end
            clause_mem[idx] = w;
            run_and_check(idx, 1'b1);
        end

        // ten back-to-back unit clauses into an eight-deep FIFO
        for (int i = 0; i < 10; i++) begin
            w = '0;
            w[0*LIT_W +: LIT_W] = {1'b1, 6'(10 + i)};
            clause_mem[20 + i] = w;
            var_asg[10 + i] = 0;
        end
        saw_full = 0; busy_viol = 0; done = 0;
        for (int n = 0; n < 300; n++) begin
            tick();
            bus.clause_valid = (n < 10);
            bus.clause_idx   = MAX_CLAUSES_BITS'(20 + n);
            #1;
            if (bus.clause_valid && bus.clause_ready) accepted.push_back(20 + n);
            if (bus.clause_valid && !bus.clause_ready) saw_full = 1;
            if (bus.push_imply) pushes.push_back(int'(bus.var_in_imply));
            if (!bus.bcp_busy && pushes.size() < accepted.size()) busy_viol++;
            if (n >= 10 && !bus.bcp_busy) begin
                done = 1;
                break;
            end
        end
        bus.clause_valid = 1'b0;
        check("burst_done", done, 1);
        check("burst_accepted", accepted.size(), DEPTH + 1);
        check("burst_saw_not_ready", saw_full, 1);
        check("burst_overflow", bus.overflow, 1);
        check("burst_busy_hold", busy_viol, 0);
        check("burst_push_count", pushes.size(), accepted.size());
        for (int i = 0; i < pushes.size() && i < accepted.size(); i++)
            check("burst_push_var", pushes[i], accepted[i] - 10);
        clear_bcp();
        check("overflow_cleared", bus.overflow, 0);

        // unit clause held back by full_imply through three EMIT cycles
        w = '0;
        w[1*LIT_W +: LIT_W] = {1'b0, 6'd20};
        clause_mem[40] = w;
        var_asg[20] = 0;
        first_push = -1; push_cnt = 0; done = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            bus.clause_valid = (n == 0);
            bus.clause_idx   = 6'd40;
            bus.full_imply   = (n < NL + 8);
            #1;
            if (bus.push_imply) begin
                push_cnt++;
                if (first_push < 0) first_push = n;
            end
            if (n > 0 && !bus.bcp_busy) begin
                done = 1;
                break;
            end
        end
        bus.clause_valid = 1'b0;
        bus.full_imply   = 1'b0;
        check("full_done", done, 1);
        check("full_push_cycle", first_push, NL + 8);
        check("full_push_once", push_cnt, 1);

        // conflict, then reset_bcp with a clause in the same cycle
        var_asg[1] = 1; var_val[1] = 0;
        var_asg[2] = 1; var_val[2] = 1;
        var_asg[3] = 1; var_val[3] = 0;
        run_and_check(5, 1'b0);
        check("conf_flag", bus.conflict, 1);
        check("conf_clause5", bus.conflict_clause, 5);
        check("conf_busy0", bus.bcp_busy, 0);
        check("conf_no_push", m_npush, 0);
        tick();
        bus.clause_valid = 1'b1;
        bus.clause_idx   = 6'd5;
        #1;
        check("conf_busy_ignores_valid", bus.bcp_busy, 0);
        tick();
        bus.clause_valid = 1'b0;
        #1;
        check("conf_sticky", bus.conflict, 1);
        check("conf_no_overflow", bus.overflow, 0);
        tick();
        reset_bcp = 1'b1;
        bus.clause_valid = 1'b1;
        #1;
        tick();
        reset_bcp = 1'b0;
        bus.clause_valid = 1'b0;
        #1;
        check("rbcp_conflict", bus.conflict, 0);
        check("rbcp_clause", bus.conflict_clause, 0);
        check("rbcp_busy", bus.bcp_busy, 0);
        check("rbcp_ready", bus.clause_ready, 1);
        rd_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            if (bus.clause_rd_en || bus.push_imply) rd_cnt++;
            tick();
        end
        check("rbcp_clause_dropped", rd_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
